// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, FSM encoding and FIFO entry layout for the coefficient fetcher.
package dct_pkg;
    localparam int ROM_LAT_DEF    = 2;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ROW_W          = 64;
    localparam int TAG_W          = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;
    typedef struct packed {
        logic [ROW_W-1:0] row1;
        logic [ROW_W-1:0] row2;
        logic [TAG_W-1:0] i;
        logic [TAG_W-1:0] j;
    } entry_t;
endpackage

// File: rtl/coef_fifo.sv
// coef_fifo: synchronous FIFO with registered head (no fall-through).
// Ports: clk, rst_n (async, active-low); wr_i/wdata_i push; rd_i pop;
//        rdata_o current head; full_o, empty_o, count_o occupancy.
module coef_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       rd_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          wr, rd;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rd      = rd_i && !empty_o;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign wr      = wr_i && (!full_o || rd);
    assign rdata_o = mem_q[rp_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= inc(wp_q);
            end
            if (rd) rp_q <= inc(rp_q);
            cnt_q <= cnt_q + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/coef_fetch.sv
// coef_fetch: streams all 64 (row i, row j) coefficient-ROM pairs of a block into a credit-limited FIFO.
// Ports: clk, rst_n (async, active-low); start/busy/done block handshake;
//        addr1/addr2 ROM row addresses, rom_dout1/rom_dout2 ROM data (ROM_LAT cycles later);
//        out_row1/out_row2/out_i/out_j/out_valid/out_ready buffered output stream.
module coef_fetch
    import dct_pkg::*;
#(
    parameter int ROM_LAT    = ROM_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       addr1,
    output logic [2:0]       addr2,
    input  logic [ROW_W-1:0] rom_dout1,
    input  logic [ROW_W-1:0] rom_dout2,
    output logic [ROW_W-1:0] out_row1,
    output logic [ROW_W-1:0] out_row2,
    output logic [2:0]       out_i,
    output logic [2:0]       out_j,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    state_e                  state_q;
    logic [5:0]              cnt_q;
    logic [5:0]              addr_q;
    logic [ROM_LAT-1:0]      vld_q;
    logic [ROM_LAT-1:0][5:0] tag_q;
    logic [CW-1:0]           inflight, fcnt;
    logic                    issue, pop, drained, fempty, ffull;
    entry_t                  wdata, head;
    always_comb begin
        inflight = '0;
        for (int k = 0; k < ROM_LAT; k++) inflight = inflight + CW'(vld_q[k]);
    end
    // Credit counts only reads already in flight or buffered; a pop this cycle frees space next cycle.
    assign issue   = state_q == FETCH && ({1'b0, inflight} + {1'b0, fcnt} < (CW + 1)'(FIFO_DEPTH));
    assign {addr1, addr2} = issue ? cnt_q : addr_q;
    assign pop     = out_valid && out_ready;
    assign drained = state_q == DRAIN && inflight == '0 && fempty;
    assign done    = drained;
    assign busy    = state_q != IDLE;
    assign out_valid = !fempty;
    assign wdata   = '{row1: rom_dout1, row2: rom_dout2,
                       i: tag_q[ROM_LAT-1][5:3], j: tag_q[ROM_LAT-1][2:0]};
    assign {out_row1, out_row2, out_i, out_j} = head;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            vld_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_q == IDLE  ? (start ? FETCH : IDLE) :
                       state_q == FETCH ? (issue && cnt_q == 6'd63 ? DRAIN : FETCH) :
                                          (drained ? IDLE : DRAIN);
            if (issue) begin
                cnt_q  <= cnt_q + 6'd1;
                addr_q <= cnt_q;
            end
            vld_q[0] <= issue;
            tag_q[0] <= cnt_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end
    coef_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (vld_q[ROM_LAT-1] && (!ffull || pop)),
        .wdata_i (wdata),
        .rd_i    (pop),
        .rdata_o (head),
        .full_o  (ffull),
        .empty_o (fempty),
        .count_o (fcnt)
    );
endmodule

// File: tb/tb_coef_fetch.sv
// tb_coef_fetch: directed bench with a block-order reference model and a 2-cycle ROM model.
module tb_coef_fetch;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic        busy, done, out_valid;
    logic [2:0]  addr1, addr2, out_i, out_j;
    logic [63:0] rom_dout1, rom_dout2, out_row1, out_row2, p1, p2;
    logic [63:0] rom [8] = '{
        64'h5A5A5A5A5A5A5A5A, 64'h7E6A4719E7B99682, 64'h7631CF8A8ACF3176, 64'h6AE782B9477E1996,
        64'h5AA6A65A5AA6A65A, 64'h4782196A96E77EB9, 64'h318A76CFCF768A31, 64'h199647827EB96AE7};
    int errs = 0, checks = 0, k = 0, ndone = 0, npairs = 0;

    coef_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .addr1(addr1), .addr2(addr2), .rom_dout1(rom_dout1), .rom_dout2(rom_dout2),
        .out_row1(out_row1), .out_row2(out_row2), .out_i(out_i), .out_j(out_j),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // ROM: address registered at the edge, data one more stage later -> valid 2 cycles after address.
    always @(posedge clk) begin
        p1 <= rom[addr1];
        p2 <= rom[addr2];
        rom_dout1 <= p1;
        rom_dout2 <= p2;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctl"}, 128'({busy, done, out_valid}), 128'(0));
        chk({nm, "_tags"}, 128'({addr1, addr2, out_i, out_j}), 128'(0));
        chk({nm, "_rows"}, {out_row1, out_row2}, 128'(0));
    endtask

    task automatic wait_done(input int lim, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < lim);
        if (!done) begin
            checks++;
            errs++;
            $display("FAIL wait_done: no done within %0d cycles", lim);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Reference model: pairs must appear in i-outer/j-inner order with rows taken from the ROM table.
    always @(negedge clk) begin
        if (!rst_n) k = 0;
        else begin
            if (out_valid) begin
                chk("tag", 128'({out_i, out_j}), 128'(k % 64));
                chk("row1", 128'(out_row1), 128'(rom[(k % 64) / 8]));
                chk("row2", 128'(out_row2), 128'(rom[k % 8]));
                if (out_i == 3'd1 && out_j == 3'd3) begin
                    chk("lit_r1", 128'(out_row1), 128'(64'h7E6A4719E7B99682));
                    chk("lit_r2", 128'(out_row2), 128'(64'h6AE782B9477E1996));
                end
                if (out_ready) begin
                    k++;
                    npairs++;
                end
            end
            if (done) begin
                chk("done_all", 128'(k), 128'(64));
                ndone++;
                k = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, np0, nd0;
        // reset state
        #12 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        // start pulse, ready held high: latency and throughput
        np0 = npairs; nd0 = ndone;
        pulse_start();
        @(negedge clk);
        chk("c1_busy", 128'(busy), 128'(1));
        @(negedge clk);
        chk("c2_addr", 128'({addr1, addr2}), 128'(6'o01));
        @(negedge clk);
        chk("c3_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("c4_valid", 128'({out_valid, out_i, out_j}), 128'(7'b1000000));
        wait_done(300, c);
        chk("done_cycle", 128'(c + 4), 128'(68));
        @(negedge clk);
        chk("after_done", 128'({busy, done}), 128'(0));
        chk("t2_pairs", 128'(npairs - np0), 128'(64));
        chk("t2_dones", 128'(ndone - nd0), 128'(1));
        // ready low after start: credit stalls after 4 issues
        np0 = npairs; nd0 = ndone;
        @(posedge clk);
        #1 start = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_addr10", 128'({addr1, addr2}), 128'(6'o03));
        chk("stall_head", 128'({out_valid, out_i, out_j}), 128'(7'b1000000));
        repeat (2) @(negedge clk);
        chk("stall_addr12", 128'({addr1, addr2}), 128'(6'o03));
        out_ready = 1'b1;
        wait_done(300, c);
        @(negedge clk);
        chk("t3_pairs", 128'(npairs - np0), 128'(64));
        chk("t3_dones", 128'(ndone - nd0), 128'(1));
        // random ready
        np0 = npairs; nd0 = ndone;
        pulse_start();
        c = 0;
        while (ndone == nd0 && c < 2000) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
            c++;
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_pairs", 128'(npairs - np0), 128'(64));
        chk("t4_dones", 128'(ndone - nd0), 128'(1));
        chk("t4_idle", 128'(busy), 128'(0));
        // reset mid-block during pair 20
        nd0 = ndone;
        pulse_start();
        c = 0;
        while (k < 20 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t5_reached20", 128'(k), 128'(20));
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_zero("post_rst");
        chk("t5_nodone", 128'(ndone - nd0), 128'(0));
        np0 = npairs; nd0 = ndone;
        pulse_start();
        wait_done(300, c);
        @(negedge clk);
        chk("t5_pairs", 128'(npairs - np0), 128'(64));
        chk("t5_dones", 128'(ndone - nd0), 128'(1));
        // start pulses while busy are ignored
        np0 = npairs; nd0 = ndone;
        pulse_start();
        repeat (3) begin
            repeat (15) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(300, c);
        repeat (6) @(negedge clk);
        chk("t6_pairs", 128'(npairs - np0), 128'(64));
        chk("t6_dones", 128'(ndone - nd0), 128'(1));
        chk("t6_idle", 128'(busy), 128'(0));
        // start held high: back-to-back blocks
        np0 = npairs; nd0 = ndone;
        @(posedge clk);
        #1 start = 1'b1;
        wait_done(300, c);
        @(negedge clk);
        chk("b2b_idle", 128'(busy), 128'(0));
        @(negedge clk);
        chk("b2b_restart", 128'(busy), 128'(1));
        start = 1'b0;
        wait_done(300, c);
        repeat (5) @(negedge clk);
        chk("b2b_pairs", 128'(npairs - np0), 128'(128));
        chk("b2b_dones", 128'(ndone - nd0), 128'(2));
        chk("b2b_end", 128'(busy), 128'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/coef_fetch.md
COEF_FETCH -- requirements
Module: coef_fetch

Interface
REQ-001 SHALL have parameter ROM_LAT, default 2, meaning cycles from address presented to data valid on rom_dout1/rom_dout2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning entries in the output buffer; it is also the maximum outstanding-plus-buffered reads.
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  meaning a one-block fetch request, sampled in IDLE only.
REQ-006 SHALL have port busy  output  1  meaning state is not IDLE.
REQ-007 SHALL have port done  output  1  meaning a one-cycle pulse when the block is fully delivered.
REQ-008 SHALL have ports addr1, addr2  output  3 each  meaning the coefficient-ROM row addresses (row i, row j).
REQ-009 SHALL have ports rom_dout1, rom_dout2  input  64 each  meaning ROM read data, valid ROM_LAT cycles after the address.
REQ-010 SHALL have ports out_row1, out_row2  output  64 each  meaning the buffered ROM rows (8 signed 8-bit coefficients, MSB byte first).
REQ-011 SHALL have ports out_i, out_j  output  3 each  meaning the address tags of the current output pair.
REQ-012 SHALL have port out_valid  output  1  meaning the output pair is valid.
REQ-013 SHALL have port out_ready  input  1  meaning the consumer accepts; transfer occurs when out_valid and out_ready are both high.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after issuing pair (7,7); DRAIN->IDLE when no reads are in flight and the FIFO is empty.
REQ-015 SHALL issue 64 address pairs per block, i outer and j inner: (0,0),(0,1)..(0,7),(1,0)..(7,7).
REQ-016 SHALL issue an address only in FETCH, and only when in-flight count + FIFO count < FIFO_DEPTH; same-cycle pops SHALL NOT be credited.
REQ-017 SHALL hold addr1/addr2 at the last issued value when not issuing; issue-valid is tracked internally by a ROM_LAT-deep valid/tag shift register.
REQ-018 SHALL write {rom_dout1, rom_dout2, i, j} into the FIFO in the cycle that an issue's valid bit exits the shift register (issue cycle + ROM_LAT).
REQ-019 SHALL present the FIFO head on the out_* ports, registered, not fall-through; out_valid = FIFO non-empty.
REQ-020 SHALL achieve its latency with start high at edge E0: first issue in cycle 1, first FIFO write at end of cycle 3, and out_valid high in cycle 4 with out_i=out_j=0.
REQ-021 SHALL sustain one pair per cycle when out_ready is held high, delivering 64 pairs in 64 consecutive cycles.
REQ-022 SHALL handle simultaneous FIFO write and pop on a full FIFO legally, with the count unchanged; overflow SHALL be impossible by credit rule.
REQ-023 SHALL pulse done for exactly one cycle, in the cycle the FSM leaves DRAIN; busy SHALL drop in the next cycle.
REQ-024 SHALL ignore start while busy; start held high SHALL begin a new block the cycle after IDLE is re-entered.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force: FSM IDLE; busy, done, out_valid 0; addr1, addr2, out_i, out_j 0; out_row1/out_row2 0; counters, valid pipe, and FIFO empty.
REQ-026 SHALL, on reset mid-block, discard all in-flight and buffered data with no done pulse, and SHALL drive nothing after release until a new start.

Structure
REQ-027 SHALL define ROM_LAT default, FIFO_DEPTH default, ROW_W=64, and the FSM state encoding in shared package dct_pkg.
REQ-028 SHALL instantiate one sub-module, coef_fifo (synchronous, parameterised width/depth, registered head, full/empty/count).

Verification
REQ-029 SHALL verify: start pulse with out_ready=1 against the 2-cycle ROM model -> out_valid in cycle 4; 64 pairs; pair (1,3) = 7E6A4719E7B99682 / 6AE782B9477E1996; done in cycle after the last transfer window.
REQ-030 SHALL verify: out_ready=0 after start -> exactly 4 issues, then addr frozen; out_valid stays 1 with head (0,0); no loss once ready=1.
REQ-031 SHALL verify: random out_ready (50%) -> all 64 pairs in order (0,0)..(7,7), each row matching ROM, one done.
REQ-032 SHALL verify: rst_n low during pair 20 -> all outputs 0 immediately; no done; the next start restarts at (0,0).
REQ-033 SHALL verify: start pulses while busy -> ignored; exactly one done; start held high -> back-to-back blocks, 128 pairs.
